// File: rtl/branch_resolution_queue.sv
// Branch resolution queue: in-order FIFO of predicted branches, resolved oldest-first by execute.
// Optional saturating resolve/mispredict counters are compiled in when BRQ_STATS_EN is defined.

package brq_pkg;
  typedef enum logic [1:0] {
    no_take     = 2'd0,
    take_weak   = 2'd1,
    take_strong = 2'd2,
    take_always = 2'd3
  } prediction_choice;
endpackage

module branch_resolution_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pipeline_en,
  input  logic                       push_valid,
  input  logic [31:0]                push_pc,
  input  brq_pkg::prediction_choice  push_pred,
  input  logic [31:0]                push_target,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic [31:0]                resolve_target,
  output logic                       update_valid,
  output logic [31:0]                update_pc,
  output logic                       update_taken,
  output logic                       mispredict,
  output logic [31:0]                redirect_pc,
  output logic                       protocol_err,
  output logic [31:0]                stat_resolved,
  output logic [31:0]                stat_mispred
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   pcMem_q   [DEPTH];
  logic          predMem_q [DEPTH];
  logic [31:0]   tgtMem_q  [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          updValid_q, updValid_d;
  logic [31:0]   updPc_q, updPc_d;
  logic          updTaken_q, updTaken_d;
  logic          misp_q, misp_d;
  logic [31:0]   redirect_q, redirect_d;
  logic          protoErr_q, protoErr_d;

  logic          isFull, isEmpty;
  logic          doPop, doPush, mispNow, protoErrNow;
  logic [31:0]   headPc, headTgt;
  logic          headPred;

  assign isFull   = (count_q == FULL_COUNT);
  assign isEmpty  = (count_q == '0);
  assign headPc   = pcMem_q[head_q];
  assign headPred = predMem_q[head_q];
  assign headTgt  = tgtMem_q[head_q];

  assign doPop   = resolve_valid & pipeline_en & ~isEmpty;
  assign mispNow = doPop & ((headPred != resolve_taken) |
                            (resolve_taken & headPred & (headTgt != resolve_target)));
  // A full queue still accepts a push when the same edge pops; a mispredict squashes it as wrong-path.
  assign doPush  = push_valid & pipeline_en & (~isFull | doPop) & ~mispNow;
  assign protoErrNow = pipeline_en & ((push_valid & isFull & ~doPop) | (resolve_valid & isEmpty));

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    updValid_d = doPop;
    updPc_d    = updPc_q;
    updTaken_d = updTaken_q;
    misp_d     = mispNow;
    redirect_d = redirect_q;
    protoErr_d = protoErr_q | protoErrNow;

    if (mispNow) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (doPop)  head_d = head_q + PW'(1);
      if (doPush) tail_d = tail_q + PW'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    if (doPop) begin
      updPc_d    = headPc;
      updTaken_d = resolve_taken;
      redirect_d = resolve_taken ? resolve_target : headPc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      updValid_q <= 1'b0;
      updPc_q    <= '0;
      updTaken_q <= 1'b0;
      misp_q     <= 1'b0;
      redirect_q <= '0;
      protoErr_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      updValid_q <= updValid_d;
      updPc_q    <= updPc_d;
      updTaken_q <= updTaken_d;
      misp_q     <= misp_d;
      redirect_q <= redirect_d;
      protoErr_q <= protoErr_d;
    end
  end

  // Entry storage carries no reset; occupancy is tracked solely by the pointers and count.
  always_ff @(posedge clk) begin
    if (doPush && !reset) begin
      pcMem_q[tail_q]   <= push_pc;
      predMem_q[tail_q] <= (push_pred != brq_pkg::no_take);
      tgtMem_q[tail_q]  <= push_target;
    end
  end

`ifdef BRQ_STATS_EN
  logic [31:0] statRes_q, statMisp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      statRes_q  <= '0;
      statMisp_q <= '0;
    end else begin
      if (doPop && (statRes_q != 32'hFFFF_FFFF))
        statRes_q <= statRes_q + 32'd1;
      if (mispNow && (statMisp_q != 32'hFFFF_FFFF))
        statMisp_q <= statMisp_q + 32'd1;
    end
  end

  assign stat_resolved = statRes_q;
  assign stat_mispred  = statMisp_q;
`else
  assign stat_resolved = '0;
  assign stat_mispred  = '0;
`endif

  assign full         = isFull;
  assign empty        = isEmpty;
  assign count        = count_q;
  assign update_valid = updValid_q;
  assign update_pc    = updPc_q;
  assign update_taken = updTaken_q;
  assign mispredict   = misp_q;
  assign redirect_pc  = redirect_q;
  assign protocol_err = protoErr_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Table-driven bench for branch_resolution_queue (DEPTH=4) with a hand-written statistics sequence.
module tb_branch_resolution_queue;
  import brq_pkg::*;

  typedef struct {
    logic             rst, en, pv;
    logic [31:0]      ppc;
    prediction_choice pred;
    logic [31:0]      ptgt;
    logic             rv, rt;
    logic [31:0]      rtgt;
    logic [2:0]       cnt;
    logic             fl, uv;
    logic [31:0]      upc;
    logic             ut, mp;
    logic [31:0]      rpc;
    logic             perr;
  } vec_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             pipeline_en = 1'b0;
  logic             push_valid = 1'b0;
  logic [31:0]      push_pc = '0;
  prediction_choice push_pred = no_take;
  logic [31:0]      push_target = '0;
  logic             full, empty;
  logic [2:0]       count;
  logic             resolve_valid = 1'b0;
  logic             resolve_taken = 1'b0;
  logic [31:0]      resolve_target = '0;
  logic             update_valid, update_taken, mispredict, protocol_err;
  logic [31:0]      update_pc, redirect_pc, stat_resolved, stat_mispred;

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[$];
  logic [31:0] expStatRes = '0;
  logic [31:0] expStatMisp = '0;

  always #5 clk = ~clk;

  branch_resolution_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .pipeline_en(pipeline_en),
    .push_valid(push_valid), .push_pc(push_pc), .push_pred(push_pred), .push_target(push_target),
    .full(full), .empty(empty), .count(count),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .mispredict(mispredict), .redirect_pc(redirect_pc), .protocol_err(protocol_err),
    .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
  );

  task automatic add(input logic rst, en, pv, input logic [31:0] ppc, input prediction_choice pred,
                     input logic [31:0] ptgt, input logic rv, rt, input logic [31:0] rtgt,
                     input logic [2:0] cnt, input logic fl, uv, input logic [31:0] upc,
                     input logic ut, mp, input logic [31:0] rpc, input logic perr);
    vec_t v;
    v.rst = rst; v.en = en; v.pv = pv; v.ppc = ppc; v.pred = pred; v.ptgt = ptgt;
    v.rv = rv; v.rt = rt; v.rtgt = rtgt; v.cnt = cnt; v.fl = fl; v.uv = uv;
    v.upc = upc; v.ut = ut; v.mp = mp; v.rpc = rpc; v.perr = perr;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst, en, pv, input logic [31:0] ppc,
                               input prediction_choice pred, input logic [31:0] ptgt,
                               input logic rv, rt, input logic [31:0] rtgt);
    @(negedge clk);
    reset = rst; pipeline_en = en;
    push_valid = pv; push_pc = ppc; push_pred = pred; push_target = ptgt;
    resolve_valid = rv; resolve_taken = rt; resolve_target = rtgt;
    @(posedge clk);
    #1;
  endtask

  task automatic checkRow(input int i, input vec_t v);
    logic [31:0] sr, sm;
`ifdef BRQ_STATS_EN
    sr = expStatRes; sm = expStatMisp;
`else
    sr = '0; sm = '0;
`endif
    checkOutput($sformatf("r%0d_count", i), 32'(count), 32'(v.cnt));
    checkOutput($sformatf("r%0d_empty", i), 32'(empty), 32'(v.cnt == 3'd0));
    checkOutput($sformatf("r%0d_full", i), 32'(full), 32'(v.fl));
    checkOutput($sformatf("r%0d_update_valid", i), 32'(update_valid), 32'(v.uv));
    checkOutput($sformatf("r%0d_update_pc", i), update_pc, v.upc);
    checkOutput($sformatf("r%0d_update_taken", i), 32'(update_taken), 32'(v.ut));
    checkOutput($sformatf("r%0d_mispredict", i), 32'(mispredict), 32'(v.mp));
    checkOutput($sformatf("r%0d_redirect_pc", i), redirect_pc, v.rpc);
    checkOutput($sformatf("r%0d_protocol_err", i), 32'(protocol_err), 32'(v.perr));
    checkOutput($sformatf("r%0d_stat_resolved", i), stat_resolved, sr);
    checkOutput($sformatf("r%0d_stat_mispred", i), stat_mispred, sm);
  endtask

  initial begin
    logic [31:0] h;
    logic        mExp;

    // Reset, simple correct not-taken resolve
    add(1,1,0,0,no_take,0, 0,0,0,        0,0,0,0,0,0,0,0);
    add(0,1,1,32'h100,no_take,0, 0,0,0,  1,0,0,0,0,0,0,0);
    add(0,1,0,0,no_take,0, 1,0,0,        0,0,1,32'h100,0,0,32'h104,0);
    add(0,1,0,0,no_take,0, 0,0,0,        0,0,0,32'h100,0,0,32'h104,0);
    // Wrong target flushes the younger entry; next push lands at slot 0
    add(0,1,1,32'h200,take_strong,32'h300, 0,0,0, 1,0,0,32'h100,0,0,32'h104,0);
    add(0,1,1,32'h208,no_take,0, 0,0,0,  2,0,0,32'h100,0,0,32'h104,0);
    add(0,1,0,0,no_take,0, 1,1,32'h304,  0,0,1,32'h200,1,1,32'h304,0);
    add(0,1,1,32'h210,no_take,0, 0,0,0,  1,0,0,32'h200,1,0,32'h304,0);
    add(0,1,0,0,no_take,0, 1,0,0,        0,0,1,32'h210,0,0,32'h214,0);
    // Direction mispredicts both ways
    add(0,1,1,32'h400,no_take,0, 0,0,0,  1,0,0,32'h210,0,0,32'h214,0);
    add(0,1,0,0,no_take,0, 1,1,32'h500,  0,0,1,32'h400,1,1,32'h500,0);
    add(0,1,1,32'h600,take_weak,32'h700, 0,0,0, 1,0,0,32'h400,1,0,32'h500,0);
    add(0,1,0,0,no_take,0, 1,0,0,        0,0,1,32'h600,0,1,32'h604,0);
    // Push+resolve same edge: correct keeps the push, mispredict discards it
    add(0,1,1,32'h800,take_always,32'h900, 0,0,0, 1,0,0,32'h600,0,0,32'h604,0);
    add(0,1,1,32'h810,no_take,0, 1,1,32'h900, 1,0,1,32'h800,1,0,32'h900,0);
    add(0,1,1,32'h820,no_take,0, 1,1,32'h999, 0,0,1,32'h810,1,1,32'h999,0);
    // Fill, overflow, push+pop while full, wrap
    add(0,1,1,32'hA00,no_take,0, 0,0,0,  1,0,0,32'h810,1,0,32'h999,0);
    add(0,1,1,32'hA04,no_take,0, 0,0,0,  2,0,0,32'h810,1,0,32'h999,0);
    add(0,1,1,32'hA08,no_take,0, 0,0,0,  3,0,0,32'h810,1,0,32'h999,0);
    add(0,1,1,32'hA0C,no_take,0, 0,0,0,  4,1,0,32'h810,1,0,32'h999,0);
    add(0,1,1,32'hA10,no_take,0, 0,0,0,  4,1,0,32'h810,1,0,32'h999,1);
    add(0,1,1,32'hA14,no_take,0, 1,0,0,  4,1,1,32'hA00,0,0,32'hA04,1);
    for (int k = 0; k < 8; k++) begin
      if (k < 3)       h = 32'hA04 + 32'(4 * k);
      else if (k == 3) h = 32'hA14;
      else             h = 32'hB00 + 32'(4 * (k - 4));
      add(0,1,1,32'hB00 + 32'(4 * k),no_take,0, 1,0,0, 4,1,1,h,0,0,h + 32'd4,1);
    end
    for (int j = 0; j < 4; j++) begin
      h = 32'hB10 + 32'(4 * j);
      add(0,1,0,0,no_take,0, 1,0,0, 3'(3 - j),0,1,h,0,0,h + 32'd4,1);
    end
    // Mid-operation reset suppresses the pulse of a same-edge resolve
    add(0,1,1,32'hD00,take_strong,32'hD80, 0,0,0, 1,0,0,32'hB1C,0,0,32'hB20,1);
    add(1,1,0,0,no_take,0, 1,0,0,        0,0,0,0,0,0,0,0);
    // pipeline_en low ignores everything; then resolve while empty
    add(0,0,1,32'hE00,no_take,0, 1,0,0,  0,0,0,0,0,0,0,0);
    add(0,1,1,32'hC00,no_take,0, 0,0,0,  1,0,0,0,0,0,0,0);
    add(0,0,1,32'hC04,no_take,0, 1,1,32'hF0, 1,0,0,0,0,0,0,0);
    add(0,1,0,0,no_take,0, 1,0,0,        0,0,1,32'hC00,0,0,32'hC04,0);
    add(0,1,0,0,no_take,0, 1,0,0,        0,0,0,32'hC00,0,0,32'hC04,1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].pv, vecs[i].ppc, vecs[i].pred,
                    vecs[i].ptgt, vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
      if (vecs[i].rst) begin
        expStatRes = '0; expStatMisp = '0;
      end else begin
        expStatRes  = expStatRes + 32'(vecs[i].uv);
        expStatMisp = expStatMisp + 32'(vecs[i].mp);
      end
      checkRow(i, vecs[i]);
    end

    // Ten push/resolve pairs with mispredicts on pairs 2, 5 and 8
    applyStimulus(1,1,0,0,no_take,0, 0,0,0);
    for (int i = 0; i < 10; i++) begin
      mExp = (i % 3 == 2);
      applyStimulus(0,1,1,32'hF00 + 32'(16 * i),no_take,0, 0,0,0);
      applyStimulus(0,1,0,0,no_take,0, 1,mExp,32'hF80);
      checkOutput($sformatf("stats%0d_mispredict", i), 32'(mispredict), 32'(mExp));
      checkOutput($sformatf("stats%0d_update_pc", i), update_pc, 32'hF00 + 32'(16 * i));
    end
    applyStimulus(0,1,0,0,no_take,0, 0,0,0);
`ifdef BRQ_STATS_EN
    checkOutput("stats_resolved", stat_resolved, 32'd10);
    checkOutput("stats_mispred", stat_mispred, 32'd3);
`else
    checkOutput("stats_resolved", stat_resolved, 32'd0);
    checkOutput("stats_mispred", stat_mispred, 32'd0);
`endif
    checkOutput("stats_count", 32'(count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolution_queue.md
# branch_resolution_queue

In-order queue of in-flight branch predictions, sitting between fetch and execute. Fetch pushes each predicted branch (PC, direction, target). Execute resolves the oldest entry with its actual outcome. The block returns the training update to the local branch predictor (PC, taken) and raises a one-cycle mispredict/redirect to the pipeline, discarding all younger wrong-path entries.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- pipeline_en  in  1  push and resolve only act when high.
- push_valid  in  1  fetch has a predicted branch.
- push_pc  in  32  branch PC.
- push_pred  in  prediction_choice  predicted direction; any value other than no_take means taken.
- push_target  in  32  predicted target, meaningful when taken.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- count  out  $clog2(DEPTH)+1  occupied entries.
- resolve_valid  in  1  execute resolves the oldest branch.
- resolve_taken  in  1  actual direction.
- resolve_target  in  32  actual target, meaningful when taken.
- update_valid  out  1  one-cycle pulse; train the predictor.
- update_pc  out  32  PC of the resolved branch.
- update_taken  out  1  actual direction, maps to the predictor's result input.
- mispredict  out  1  one-cycle pulse; flush the front end.
- redirect_pc  out  32  correct next PC, valid with mispredict.
- protocol_err  out  1  sticky; push while full or resolve while empty.
- stat_resolved  out  32  resolved-branch count (see Configuration).
- stat_mispred  out  32  mispredict count (see Configuration).

## Operation
- Storage is a circular buffer of DEPTH entries {pc, pred_taken, target}, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a separate count.
- Push happens when push_valid & pipeline_en & !full. The entry is written at tail, tail increments and count increments.
- Pop happens when resolve_valid & pipeline_en & !empty. The head entry is compared with the outcome.
  - Mispredict = (pred_taken != resolve_taken) | (resolve_taken & pred_taken & target != resolve_target).
  - redirect_pc = resolve_taken ? resolve_target : head.pc + 32'd4, with 32-bit wrap.
- Every pop updates the predictor: update_valid=1, update_pc=head.pc, update_taken=resolve_taken.
- Popping without a mispredict advances head and decrements count.
- Popping with a mispredict flushes the queue: head=tail=0, count=0, and any same-cycle push is discarded as wrong-path.
- Push and pop in the same cycle without a mispredict: both happen and count is unchanged. This is legal even when full, because the pop frees a slot.
  - Full is evaluated on the pre-pop count. A push while full is dropped unless a pop occurs in the same cycle.
- A push dropped while full, or a resolve_valid while empty, sets protocol_err, held until reset. A resolve while empty produces no update and no mispredict.
- While pipeline_en is low, push and resolve are ignored and no error is flagged.

## Timing
- Reset values:
  - empty=1, full=0, count=0.
  - update_valid=0, update_pc=0, update_taken=0.
  - mispredict=0, redirect_pc=0.
  - protocol_err=0, stat_*=0.
  - Pointers are 0.
- full, empty and count are registered state, so they reflect cycle N's push/pop from cycle N+1.
- update_* and mispredict/redirect_pc are registered: a resolve at edge N is visible during cycle N+1 and held for exactly one cycle. update_pc, update_taken and redirect_pc hold their values until the next pop.
- Back-to-back resolves produce back-to-back pulses.
- Reset asserted mid-operation empties the queue at that edge and suppresses any pulse that a same-cycle resolve would have produced.
- A resolve and a push at the same edge: the pushed entry can be resolved from the next cycle.

## Configuration
- BRQ_STATS_EN defined:
  - stat_resolved increments once per pop.
  - stat_mispred increments once per mispredict.
  - Both are saturating at 32'hFFFF_FFFF and cleared by reset; they update on the same edge as the pop.
- BRQ_STATS_EN undefined: both counters are absent and stat_resolved and stat_mispred are tied to 0. All other behaviour is identical.

## Test plan
- Reset, then push pc=0x100 pred=no_take, then resolve taken=0: update_valid pulse with update_pc=0x100, update_taken=0, mispredict=0, count back to 0.
- Push 0x200 predicted taken with target 0x300, then resolve taken with target 0x304: mispredict=1 with redirect_pc=0x304. A prior push of 0x208 is flushed, so empty=1 the next cycle.
- Push 0x400 pred=no_take, then resolve taken=1 with target 0x500: mispredict=1, redirect_pc=0x500. Separately, push 0x600 predicted taken, then resolve not-taken: redirect_pc=0x604.
- Fill to DEPTH=4, then push a 5th: full=1, the 5th is dropped and protocol_err=1. Then push and resolve in the same cycle with the correct prediction: count stays 4 and the new entry is accepted; pointers wrap correctly across 8 further entries.
- Resolve while empty: no update_valid and protocol_err=1. With pipeline_en=0, push and resolve have no effect on count or outputs.
- With BRQ_STATS_EN, run 10 resolves including 3 mispredicts: stat_resolved=10, stat_mispred=3. Without it, both read 0.
